instr_fetch_unit: RTL



---
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the instruction-memory handshake
// and hands instruction/PC/PC+4 to the control path, honouring redirects.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,

    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,

    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instruction,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc4,

    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              squash_q, squash_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic [ADDR_W-1:0] pc4_q, pc4_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] target;
    logic              target_mis;
    logic [ADDR_W-1:0] next_pc;

    assign target     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign target_mis = |redirect_pc[1:0];

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        squash_d = squash_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        pc4_d    = pc4_q;
        err_d    = 1'b0;
        next_pc  = pc_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                addr_d  = pc_q;
            end

            FETCH: begin
                err_d = redirect_valid & target_mis;
                if (imem_ready) begin
                    // A squashed or same-cycle-redirected return is dropped and
                    // the request restarts from the up-to-date PC.
                    if (squash_q || redirect_valid) begin
                        next_pc  = redirect_valid ? target : pc_q;
                        pc_d     = next_pc;
                        addr_d   = next_pc;
                        squash_d = 1'b0;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = addr_q;
                        pc4_d    = addr_q + WORD;
                        state_d  = DELIVER;
                    end
                end else if (redirect_valid) begin
                    // Outstanding request must complete on its old address.
                    pc_d     = target;
                    squash_d = 1'b1;
                end
            end

            DELIVER: begin
                if (instr_ready || redirect_valid) begin
                    next_pc = redirect_valid ? target : pc4_q;
                    pc_d    = next_pc;
                    addr_d  = next_pc;
                    state_d = FETCH;
                    err_d   = redirect_valid & target_mis;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            squash_q <= 1'b0;
            instr_q  <= 32'h0;
            pc_out_q <= RESET_PC;
            pc4_q    <= RESET_PC + WORD;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            squash_q <= squash_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            pc4_q    <= pc4_d;
            err_q    <= err_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == DELIVER);
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign pc4         = pc4_q;
    assign fetch_err   = err_q;

endmodule
